shift_issue_stage: RTL and testbench
====================================

# shift_issue_stage

Registered issue/result stage that feeds the 8-bit rotate-right barrel shifter and holds its output. It accepts one shift command at a time through a valid/ready handshake and maps it onto a rotate-right amount plus a fill mask. It registers the 8-bit result with zero and carry flags and holds it until the consumer takes it. It sits between the ALU operand/opcode decode and the ALU result mux.

## Interface
- No parameters; datapath fixed at 8 bits, amount at 3 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  stage can accept a command this cycle.
- in_op  in  3  000 ROR, 001 ROL, 010 SHR logical, 011 SAR arithmetic, 100 SHL, 101–111 illegal.
- in_data  in  8  operand.
- in_amt  in  3  shift/rotate amount, 0–7.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- out_data  out  8  result.
- out_zero  out  1  out_data == 0.
- out_carry  out  1  last bit shifted/rotated out.
- out_err  out  1  command used an illegal op.
- busy  out  1  state != IDLE.
- done_cnt  out  8  count of completed output transfers, wraps 255→0.

## Operation
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: capture op/data/amt, go CALC.
- CALC:
  - in_ready=0.
  - Compute the result from the captured fields and register out_data, out_zero, out_carry, out_err.
  - Set out_valid, go HOLD.
- HOLD:
  - out_valid=1; outputs stable.
  - out_ready=0: stay in HOLD.
  - out_ready=1 and in_valid=1: complete the transfer, accept the new command in the same cycle, go CALC.
  - out_ready=1 and in_valid=0: go IDLE.
  - in_ready = out_ready while in HOLD.
- Accepted fields are internal registers; later changes on in_* do not affect an accepted command.
- Amount mapping onto the rotate-right core, with a = amt:
  - ROR uses a.
  - ROL uses (8−a) mod 8.
  - SHR: ROR by a, then clear the top a bits.
  - SAR: ROR by a, then fill the top a bits with data[7].
  - SHL: ROR by (8−a) mod 8, then clear the low a bits.
- Carry, defined only for a≠0:
  - ROR: result[7].
  - ROL: result[0].
  - SHR/SAR: data[a−1].
  - SHL: data[8−a].
- Carry is 0 when a=0; in that case the result equals data for every legal op.
- Illegal op: out_data=in_data, out_carry=0, out_err=1, out_zero computed normally.
- done_cnt increments on every cycle with out_valid && out_ready.

## Timing
- Reset (asynchronous, rst_n low) clears:
  - state=IDLE, so in_ready=1 and busy=0.
  - out_valid=0, out_data=0x00, out_zero=0, out_carry=0, out_err=0, done_cnt=0.
- Reset mid-operation (CALC or HOLD) discards the command and any pending result; no transfer is counted.
- Latency: command accepted at edge N; out_valid=1 from edge N+1.
- Peak throughput: one command per 2 cycles, reached when out_ready stays high and in_valid stays high.
- Once out_valid is high it does not drop, and out_data/flags do not change, until out_ready is sampled high.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored; the upstream must hold the command until in_ready.

## Test plan
- Reset with rst_n=0 mid-HOLD holding 0xC0 → all outputs at reset values immediately; after release, in_ready=1, done_cnt=0.
- ROR 0x81 amt 1 → 0xC0, carry 1, zero 0. ROL 0x81 amt 1 → 0x03, carry 1.
- SAR 0x80 amt 3 → 0xF0, carry 0.
- SHR 0x01 amt 1 → 0x00, zero 1, carry 1.
- SHL 0xFF amt 4 → 0xF0, carry 1.
- Any op with amt 0 on 0x5A → 0x5A, carry 0.
- Op 110 on 0x3C → 0x3C, err 1.
- Backpressure and counter:
  - Hold out_ready=0 for 5 cycles after out_valid; out_data stays stable and in_ready=0.
  - Then raise out_ready with in_valid=1 → transfer and accept in the same cycle, next result valid one cycle later.
  - Run back-to-back for 300 transfers → done_cnt=44 (300 mod 256).

Source files
------------

// File: rtl/shift_issue_if.sv
// Handshake bundle between operand decode, the shift issue stage and the result mux.
// The master side issues commands and takes results; the slave side is the stage.
interface shift_issue_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;
    logic       out_carry;
    logic       out_err;

    modport master (
        output in_valid, in_op, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_carry, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_carry, out_err
    );
endinterface

// File: rtl/shift_issue_stage.sv
// Issue/result stage around an 8-bit rotate-right core: every shift op is mapped
// onto a rotate amount plus a fill mask, and the registered result is held until taken.
module shift_issue_stage (
    input  logic          clk,
    input  logic          rst_n,
    shift_issue_if.slave  bus,
    output logic          busy,
    output logic [7:0]    done_cnt
);

    localparam logic [2:0] OP_ROR = 3'b000;
    localparam logic [2:0] OP_ROL = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_SAR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              in_ready_c;
    logic              accept;
    logic              xfer;

    logic [2:0]        op_p0;
    logic signed [7:0] data_p0;
    logic [2:0]        amt_p0;

    logic              vld_p1;
    logic [7:0]        data_p1;
    logic              zero_p1;
    logic              carry_p1;
    logic              err_p1;

    logic [7:0]        res_c;
    logic              carry_c;
    logic              err_c;

    function automatic logic [7:0] ror8(input logic [7:0] d, input logic [2:0] a);
        logic [15:0] w;
        w = {d, d} >> a;
        return w[7:0];
    endfunction

    // Top a bits set; a=0 gives an empty mask.
    function automatic logic [7:0] top_mask(input logic [2:0] a);
        return ~(8'hFF >> a);
    endfunction

    // Low a bits set; a=0 gives an empty mask.
    function automatic logic [7:0] low_mask(input logic [2:0] a);
        return ~(8'hFF << a);
    endfunction

    function automatic logic [7:0] shift_result(input logic [2:0] op,
                                                input logic [7:0] d,
                                                input logic [2:0] a);
        logic [2:0] neg_a;
        neg_a = 3'd0 - a;
        case (op)
            OP_ROR:  return ror8(d, a);
            OP_ROL:  return ror8(d, neg_a);
            OP_SHR:  return ror8(d, a) & ~top_mask(a);
            OP_SAR:  return d[7] ? (ror8(d, a) | top_mask(a)) : (ror8(d, a) & ~top_mask(a));
            OP_SHL:  return ror8(d, neg_a) & ~low_mask(a);
            default: return d;
        endcase
    endfunction

    function automatic logic shift_carry(input logic [2:0] op,
                                         input logic [7:0] d,
                                         input logic [2:0] a,
                                         input logic [7:0] r);
        logic [2:0] lsb_out;
        logic [2:0] msb_out;
        lsb_out = a - 3'd1;
        msb_out = 3'd0 - a;
        if (a == 3'd0) return 1'b0;
        case (op)
            OP_ROR:         return r[7];
            OP_ROL:         return r[0];
            OP_SHR, OP_SAR: return d[lsb_out];
            OP_SHL:         return d[msb_out];
            default:        return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d = HOLD;
            end
            HOLD: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    accept  = bus.in_valid;
                    state_d = bus.in_valid ? CALC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Stage p0: accepted command fields, isolated from later changes on the bus.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0   <= bus.in_op;
            data_p0 <= bus.in_data;
            amt_p0  <= bus.in_amt;
        end
    end

    always_comb begin
        res_c   = shift_result(op_p0, data_p0, amt_p0);
        err_c   = (op_p0 > OP_SHL);
        carry_c = err_c ? 1'b0 : shift_carry(op_p0, data_p0, amt_p0, res_c);
    end

    assign xfer = vld_p1 && bus.out_ready;

    // Stage p1: registered result, held stable while waiting for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            data_p1  <= 8'h00;
            zero_p1  <= 1'b0;
            carry_p1 <= 1'b0;
            err_p1   <= 1'b0;
        end else if (state_q == CALC) begin
            vld_p1   <= 1'b1;
            data_p1  <= res_c;
            zero_p1  <= (res_c == 8'h00);
            carry_p1 <= carry_c;
            err_p1   <= err_c;
        end else if (xfer) begin
            vld_p1   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    done_cnt <= 8'd0;
        else if (xfer) done_cnt <= done_cnt + 8'd1;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_zero  = zero_p1;
    assign bus.out_carry = carry_p1;
    assign bus.out_err   = err_p1;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: directed commands push hand-computed
// results; a monitor pops and compares on every output transfer.
module tb_shift_issue_stage;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] done_cnt;

    shift_issue_if bus();

    shift_issue_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       z;
        logic       c;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got data 0x%0h with no pending command", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    total--;
                    check("result{data,zero,carry,err}",
                          {23'd0, bus.out_data, bus.out_zero, bus.out_carry, bus.out_err},
                          {23'd0, e});
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a,
                        input logic [7:0] ed, input logic ez, input logic ec, input logic ee);
        bit ok;
        exp_q.push_back('{d: ed, z: ez, c: ec, e: ee});
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 required 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL valid_timeout: out_valid stayed 0 required 1");
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] r;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_data   = 8'h00;
        bus.in_amt    = 3'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_in_ready", bus.in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_data", bus.out_data, 0);
        check("reset_flags", {bus.out_zero, bus.out_carry, bus.out_err}, 0);
        check("reset_done_cnt", done_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed results.
        send(3'b000, 8'h81, 3'd1, 8'hC0, 1'b0, 1'b1, 1'b0);
        send(3'b001, 8'h81, 3'd1, 8'h03, 1'b0, 1'b1, 1'b0);
        send(3'b011, 8'h80, 3'd3, 8'hF0, 1'b0, 1'b0, 1'b0);
        send(3'b010, 8'h01, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0);
        send(3'b100, 8'hFF, 3'd4, 8'hF0, 1'b0, 1'b1, 1'b0);
        send(3'b010, 8'hB4, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0);
        send(3'b011, 8'h3F, 3'd2, 8'h0F, 1'b0, 1'b1, 1'b0);
        send(3'b100, 8'h81, 3'd7, 8'h80, 1'b0, 1'b0, 1'b0);
        send(3'b000, 8'h12, 3'd4, 8'h21, 1'b0, 1'b0, 1'b0);
        for (int op = 0; op < 5; op++)
            send(3'(op), 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        send(3'b110, 8'h3C, 3'd2, 8'h3C, 1'b0, 1'b0, 1'b1);
        send(3'b101, 8'h00, 3'd5, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_drain();
        check("done_cnt_directed", done_cnt, 16);

        // Backpressure: result held for five stalled cycles, then transfer+accept together.
        bus.out_ready = 1'b0;
        send(3'b000, 8'h81, 3'd1, 8'hC0, 1'b0, 1'b1, 1'b0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("stall_out_data", bus.out_data, 8'hC0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        exp_q.push_back('{d: 8'hF0, z: 1'b0, c: 1'b1, e: 1'b0});
        bus.in_op     = 3'b100;
        bus.in_data   = 8'hFF;
        bus.in_amt    = 3'd4;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("hold_in_ready_follows_out_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        check("calc_gap_out_valid", bus.out_valid, 0);
        @(negedge clk);
        check("next_out_valid", bus.out_valid, 1);
        wait_drain();
        check("done_cnt_backpressure", done_cnt, 18);

        // Asynchronous reset while holding 0xC0 discards the pending result.
        bus.out_ready = 1'b0;
        send(3'b000, 8'h81, 3'd1, 8'hC0, 1'b0, 1'b1, 1'b0);
        wait_valid();
        check("pre_reset_hold_data", bus.out_data, 8'hC0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_out_data", bus.out_data, 0);
        check("midreset_flags", {bus.out_zero, bus.out_carry, bus.out_err}, 0);
        check("midreset_done_cnt", done_cnt, 0);
        check("midreset_busy", busy, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        exp_q.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postreset_in_ready", bus.in_ready, 1);
        check("postreset_done_cnt", done_cnt, 0);
        check("postreset_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Back-to-back stream of 300 ROL-by-1 commands; the counter wraps to 44.
        for (int i = 0; i < 300; i++) begin
            d = 8'(i);
            r = {d[6:0], d[7]};
            send(3'b001, d, 3'd1, r, (r == 8'h00), d[7], 1'b0);
        end
        wait_drain();
        check("done_cnt_wrap", done_cnt, 44);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
